// File: rtl/ram_tdp_nc.sv
// True dual-port RAM with byte enables, per-port read-during-write mode,
// optional output register stage, cross-port collision flag and zeroing sweep.
module ram_tdp_nc #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 64,
  parameter int RDW_MODE  = 0,
  parameter int OUT_REG   = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic                   clk,
  input  logic                   rst_i,
  output logic                   init_done_o,
  input  logic                   a_en,
  input  logic [DATA_BITS/8-1:0] a_we,
  input  logic [ADDR_BITS-1:0]   a_addr,
  input  logic [DATA_BITS-1:0]   a_data_in,
  output logic [DATA_BITS-1:0]   a_data_out,
  output logic                   a_valid_o,
  input  logic                   b_en,
  input  logic [DATA_BITS/8-1:0] b_we,
  input  logic [ADDR_BITS-1:0]   b_addr,
  input  logic [DATA_BITS-1:0]   b_data_in,
  output logic [DATA_BITS-1:0]   b_data_out,
  output logic                   b_valid_o,
  output logic                   collision_o
);

  localparam int NB    = DATA_BITS / 8;
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] CNT_ONE   = ADDR_BITS'(1);

  typedef enum logic {INIT, READY} state_t;

  state_t                 state_q;
  logic [ADDR_BITS-1:0]   initCnt_q;
  logic [DATA_BITS-1:0]   mem [DEPTH];

  logic                   ready, aAcc, bAcc;
  logic [DATA_BITS-1:0]   aOld, bOld;
  logic [DATA_BITS-1:0]   aData1_d, bData1_d, aData1_q, bData1_q;
  logic                   aValid1_d, bValid1_d, aValid1_q, bValid1_q;
  logic                   collision_d, collision_q;

  function automatic logic [DATA_BITS-1:0] mergeBytes(input logic [DATA_BITS-1:0] oldW,
                                                      input logic [DATA_BITS-1:0] newW,
                                                      input logic [NB-1:0]        we);
    logic [DATA_BITS-1:0] r;
    r = oldW;
    for (int i = 0; i < NB; i++)
      if (we[i]) r[i*8 +: 8] = newW[i*8 +: 8];
    return r;
  endfunction

  assign ready       = (state_q == READY);
  assign init_done_o = ready;
  assign aAcc        = a_en && ready;
  assign bAcc        = b_en && ready;
  assign aOld        = mem[a_addr];
  assign bOld        = mem[b_addr];

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= INIT;
      initCnt_q <= '0;
    end else if (state_q == INIT) begin
      if (INIT_ZERO == 0 || initCnt_q == LAST_ADDR) state_q <= READY;
      initCnt_q <= initCnt_q + CNT_ONE;
    end
  end

  // B is written before A so that A owns any byte both ports write.
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      if (state_q == INIT) begin
        if (INIT_ZERO != 0) mem[initCnt_q] <= '0;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (bAcc && b_we[i]) mem[b_addr][i*8 +: 8] <= b_data_in[i*8 +: 8];
          if (aAcc && a_we[i]) mem[a_addr][i*8 +: 8] <= a_data_in[i*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    aData1_d  = aData1_q;
    aValid1_d = 1'b0;
    bData1_d  = bData1_q;
    bValid1_d = 1'b0;
    if (aAcc) begin
      case (RDW_MODE)
        1: begin aData1_d = mergeBytes(aOld, a_data_in, a_we); aValid1_d = 1'b1; end
        2: if (a_we == '0) begin aData1_d = aOld; aValid1_d = 1'b1; end
        default: begin aData1_d = aOld; aValid1_d = 1'b1; end
      endcase
    end
    if (bAcc) begin
      case (RDW_MODE)
        1: begin bData1_d = mergeBytes(bOld, b_data_in, b_we); bValid1_d = 1'b1; end
        2: if (b_we == '0) begin bData1_d = bOld; bValid1_d = 1'b1; end
        default: begin bData1_d = bOld; bValid1_d = 1'b1; end
      endcase
    end
    collision_d = aAcc && bAcc && (a_addr == b_addr) && ((a_we != '0) || (b_we != '0));
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      aData1_q    <= '0;
      aValid1_q   <= 1'b0;
      bData1_q    <= '0;
      bValid1_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      aData1_q    <= aData1_d;
      aValid1_q   <= aValid1_d;
      bData1_q    <= bData1_d;
      bValid1_q   <= bValid1_d;
      collision_q <= collision_d;
    end
  end

  assign collision_o = collision_q;

  if (OUT_REG != 0) begin : g_outReg
    logic [DATA_BITS-1:0] aData2_q, bData2_q;
    logic                 aValid2_q, bValid2_q;

    always_ff @(posedge clk) begin
      if (rst_i) begin
        aData2_q  <= '0;
        aValid2_q <= 1'b0;
        bData2_q  <= '0;
        bValid2_q <= 1'b0;
      end else begin
        if (aValid1_q) aData2_q <= aData1_q;
        if (bValid1_q) bData2_q <= bData1_q;
        aValid2_q <= aValid1_q;
        bValid2_q <= bValid1_q;
      end
    end

    assign a_data_out = aData2_q;
    assign a_valid_o  = aValid2_q;
    assign b_data_out = bData2_q;
    assign b_valid_o  = bValid2_q;
  end else begin : g_noOutReg
    assign a_data_out = aData1_q;
    assign a_valid_o  = aValid1_q;
    assign b_data_out = bData1_q;
    assign b_valid_o  = bValid1_q;
  end

endmodule
